// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXE/MEM/WB sequencer.
// Optional bne decode is enabled by defining CTRL_BNE_EN.
module multi_cycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic [1:0] npc_op,
  output logic       rf_wr,
  output logic [1:0] rf_dst,
  output logic [1:0] wd_sel,
  output logic [2:0] alu_op,
  output logic       alu_src_b,
  output logic [1:0] ext_op,
  output logic       dm_wr,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB     = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic is_r, r_alu, i_jr;
  logic i_ori, i_lui, i_addiu;
  logic i_lw, i_sw, i_beq, i_bne;
  logic i_j, i_jal, legal;
  logic [2:0] dec_alu;
  logic       dec_srcb;
  logic [1:0] dec_ext;

  always_comb begin
    is_r    = (op == 6'b000000);
    r_alu   = is_r && (funct == 6'b100001 ||
                       funct == 6'b100011 ||
                       funct == 6'b100100 ||
                       funct == 6'b100101 ||
                       funct == 6'b101010);
    i_jr    = is_r && (funct == 6'b001000);
    i_ori   = (op == 6'b001101);
    i_lui   = (op == 6'b001111);
    i_addiu = (op == 6'b001001);
    i_lw    = (op == 6'b100011);
    i_sw    = (op == 6'b101011);
    i_beq   = (op == 6'b000100);
    i_j     = (op == 6'b000010);
    i_jal   = (op == 6'b000011);
`ifdef CTRL_BNE_EN
    i_bne   = (op == 6'b000101);
`else
    i_bne   = 1'b0;
`endif
    legal   = r_alu | i_jr | i_ori | i_lui |
              i_addiu | i_lw | i_sw | i_beq |
              i_bne | i_j | i_jal;
  end

  always_comb begin
    dec_alu  = 3'b000;
    dec_srcb = 1'b0;
    dec_ext  = 2'b00;
    unique case (1'b1)
      r_alu: begin
        unique case (funct)
          6'b100011: dec_alu = 3'b001;
          6'b100100: dec_alu = 3'b010;
          6'b100101: dec_alu = 3'b011;
          6'b101010: dec_alu = 3'b100;
          default:   dec_alu = 3'b000;
        endcase
      end
      i_ori: begin
        dec_alu  = 3'b011;
        dec_srcb = 1'b1;
      end
      i_lui: begin
        dec_alu  = 3'b101;
        dec_srcb = 1'b1;
        dec_ext  = 2'b10;
      end
      (i_addiu | i_lw | i_sw): begin
        dec_srcb = 1'b1;
        dec_ext  = 2'b01;
      end
      (i_beq | i_bne): begin
        dec_alu = 3'b001;
        dec_ext = 2'b01;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = S_FETCH;
    pc_wr     = 1'b0;
    ir_wr     = 1'b0;
    npc_op    = 2'b00;
    rf_wr     = 1'b0;
    rf_dst    = 2'b00;
    wd_sel    = 2'b00;
    alu_op    = 3'b000;
    alu_src_b = 1'b0;
    ext_op    = 2'b00;
    dm_wr     = 1'b0;
    illegal   = 1'b0;
    // ALU/ext selects stay up from EXE through WB
    if (state_q inside {S_EXE, S_MEM_RD, S_MEM_WR, S_WB}) begin
      alu_op    = dec_alu;
      alu_src_b = dec_srcb;
      ext_op    = dec_ext;
    end
    case (state_q)
      S_FETCH: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (i_j || i_jal) begin
          pc_wr  = 1'b1;
          npc_op = 2'b10;
          if (i_jal) begin
            rf_wr  = 1'b1;
            rf_dst = 2'b10;
            wd_sel = 2'b10;
          end
        end else if (i_jr) begin
          pc_wr  = 1'b1;
          npc_op = 2'b11;
        end else if (!legal) begin
          illegal = 1'b1;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (i_beq || i_bne) begin
          pc_wr  = i_beq ? zero : ~zero;
          npc_op = 2'b01;
        end else if (i_lw) begin
          state_d = S_MEM_RD;
        end else if (i_sw) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM_RD: state_d = S_WB;
      S_MEM_WR: dm_wr = 1'b1;
      S_WB: begin
        rf_wr  = 1'b1;
        rf_dst = is_r ? 2'b01 : 2'b00;
        wd_sel = i_lw ? 2'b01 : 2'b00;
      end
      default: state_d = S_FETCH;
    endcase
    // reset abandons the instruction in flight
    if (rst) begin
      pc_wr     = 1'b0;
      ir_wr     = 1'b0;
      npc_op    = 2'b00;
      rf_wr     = 1'b0;
      rf_dst    = 2'b00;
      wd_sel    = 2'b00;
      alu_op    = 3'b000;
      alu_src_b = 1'b0;
      ext_op    = 2'b00;
      dm_wr     = 1'b0;
      illegal   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Table-driven scoreboard bench for multi_cycle_ctrl.
// Builds per-cycle expected output vectors from an instruction table.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       pc_wr, ir_wr, rf_wr, alu_src_b, dm_wr, illegal;
  logic [1:0] npc_op, rf_dst, wd_sel, ext_op;
  logic [2:0] alu_op, state;

  multi_cycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .npc_op(npc_op), .rf_wr(rf_wr),
    .rf_dst(rf_dst), .wd_sel(wd_sel), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .ext_op(ext_op), .dm_wr(dm_wr),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic [1:0] npc;
    logic       rf_wr;
    logic [1:0] dst;
    logic [1:0] wd;
    logic [2:0] alu;
    logic       srcb;
    logic [1:0] ext;
    logic       dm;
    logic       ill;
    logic [2:0] st;
  } ovec_t;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4;
  localparam int K_J = 5, K_JAL = 6, K_JR = 7, K_ILL = 8;

  typedef struct {
    string      nm;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         kind;
    logic [2:0] alu;
    logic       srcb;
    logic [1:0] ext;
    logic       taken;
  } rec_t;

  ovec_t q[$];
  rec_t  tbl[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic rec_t mk(string nm, logic [5:0] o, logic [5:0] f,
                              logic z, int k, logic [2:0] a,
                              logic sb, logic [1:0] e, logic t);
    rec_t r;
    r.nm = nm; r.op = o; r.funct = f; r.zero = z; r.kind = k;
    r.alu = a; r.srcb = sb; r.ext = e; r.taken = t;
    return r;
  endfunction

  function automatic ovec_t actual();
    ovec_t v;
    v.pc_wr = pc_wr; v.ir_wr = ir_wr; v.npc = npc_op;
    v.rf_wr = rf_wr; v.dst = rf_dst; v.wd = wd_sel;
    v.alu = alu_op; v.srcb = alu_src_b; v.ext = ext_op;
    v.dm = dm_wr; v.ill = illegal; v.st = state;
    return v;
  endfunction

  function automatic void push_expected(rec_t r);
    ovec_t v;
    v = '0; v.pc_wr = 1; v.ir_wr = 1;
    q.push_back(v);
    v = '0; v.st = 3'd1;
    case (r.kind)
      K_J:   begin v.pc_wr = 1; v.npc = 2'b10; end
      K_JAL: begin
        v.pc_wr = 1; v.npc = 2'b10;
        v.rf_wr = 1; v.dst = 2'b10; v.wd = 2'b10;
      end
      K_JR:  begin v.pc_wr = 1; v.npc = 2'b11; end
      K_ILL: v.ill = 1;
      default: ;
    endcase
    q.push_back(v);
    if (r.kind inside {K_J, K_JAL, K_JR, K_ILL}) return;
    v = '0; v.alu = r.alu; v.srcb = r.srcb; v.ext = r.ext;
    v.st = 3'd2;
    if (r.kind == K_BR) begin
      v.pc_wr = r.taken; v.npc = 2'b01;
      q.push_back(v);
      return;
    end
    q.push_back(v);
    if (r.kind == K_LW) begin
      v.st = 3'd3;
      q.push_back(v);
    end
    if (r.kind == K_SW) begin
      v.st = 3'd4; v.dm = 1;
      q.push_back(v);
      return;
    end
    v.st = 3'd5; v.rf_wr = 1;
    v.dst = (r.kind == K_R) ? 2'b01 : 2'b00;
    v.wd  = (r.kind == K_LW) ? 2'b01 : 2'b00;
    q.push_back(v);
  endfunction

  task automatic check_cycle(string nm);
    ovec_t e, a;
    @(negedge clk);
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = q.pop_front();
      a = actual();
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got %b required %b", nm, a, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(rec_t r);
    op = r.op;
    funct = (r.op == 6'd0) ? r.funct : 6'($urandom_range(63));
    zero = r.zero;
    push_expected(r);
    while (q.size() > 0) check_cycle(r.nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    tbl.push_back(mk("addu",  6'h00, 6'h21, 0, K_R,   3'd0, 0, 2'd0, 0));
    tbl.push_back(mk("lw",    6'h23, 6'h00, 0, K_LW,  3'd0, 1, 2'd1, 0));
    tbl.push_back(mk("sw",    6'h2b, 6'h00, 0, K_SW,  3'd0, 1, 2'd1, 0));
    tbl.push_back(mk("subu",  6'h00, 6'h23, 0, K_R,   3'd1, 0, 2'd0, 0));
    tbl.push_back(mk("and",   6'h00, 6'h24, 1, K_R,   3'd2, 0, 2'd0, 0));
    tbl.push_back(mk("or",    6'h00, 6'h25, 0, K_R,   3'd3, 0, 2'd0, 0));
    tbl.push_back(mk("slt",   6'h00, 6'h2a, 0, K_R,   3'd4, 0, 2'd0, 0));
    tbl.push_back(mk("ori",   6'h0d, 6'h00, 0, K_I,   3'd3, 1, 2'd0, 0));
    tbl.push_back(mk("lui",   6'h0f, 6'h00, 0, K_I,   3'd5, 1, 2'd2, 0));
    tbl.push_back(mk("addiu", 6'h09, 6'h00, 0, K_I,   3'd0, 1, 2'd1, 0));
    tbl.push_back(mk("beq_z1",6'h04, 6'h00, 1, K_BR,  3'd1, 0, 2'd1, 1));
    tbl.push_back(mk("beq_z0",6'h04, 6'h00, 0, K_BR,  3'd1, 0, 2'd1, 0));
    tbl.push_back(mk("jal",   6'h03, 6'h00, 0, K_JAL, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk("j",     6'h02, 6'h00, 0, K_J,   3'd0, 0, 2'd0, 0));
    tbl.push_back(mk("jr",    6'h00, 6'h08, 0, K_JR,  3'd0, 0, 2'd0, 0));
    tbl.push_back(mk("ill_op",6'h3f, 6'h00, 0, K_ILL, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk("ill_fn",6'h00, 6'h00, 0, K_ILL, 3'd0, 0, 2'd0, 0));
`ifdef CTRL_BNE_EN
    tbl.push_back(mk("bne_z0",6'h05, 6'h00, 0, K_BR,  3'd1, 0, 2'd1, 1));
    tbl.push_back(mk("bne_z1",6'h05, 6'h00, 1, K_BR,  3'd1, 0, 2'd1, 0));
`else
    tbl.push_back(mk("bne_z0",6'h05, 6'h00, 0, K_ILL, 3'd0, 0, 2'd0, 0));
`endif

    // power-on reset: everything quiet, state FETCH
    rst = 1;
    q.push_back('0);
    check_cycle("reset0");
    q.push_back('0);
    check_cycle("reset1");
    rst = 0;

    for (int i = 0; i < tbl.size(); i++) run_instr(tbl[i]);

    // reset held 3 cycles starting in WB of addu
    op = 6'h00; funct = 6'h21; zero = 0;
    push_expected(tbl[0]);
    for (int i = 0; i < 3; i++) check_cycle("addu_pre_rst");
    void'(q.pop_back());
    rst = 1;
    begin
      ovec_t v;
      v = '0; v.st = 3'd5;
      q.push_back(v);
    end
    check_cycle("rst_in_wb");
    q.push_back('0);
    check_cycle("rst_hold1");
    q.push_back('0);
    check_cycle("rst_hold2");
    rst = 0;

    // first fetch right after release, then a full lw and jal
    run_instr(tbl[1]);
    run_instr(tbl[12]);
    run_instr(tbl[10]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
